rom_programmer: RTL and testbench

ROM_PROGRAMMER -- requirements
Module: rom_programmer

---
 rtl/rom_programmer.sv | 164 ++++++++++++++++
 tb/tb_rom_programmer.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rom_programmer.sv
// rom_programmer: burns WORD_COUNT words into a 556PT4/PT5 bipolar PROM with timed setup/pulse/recover
// phases. Define ROM_PROGRAMMER_VERIFY_EN to enable read-back verify with bounded retries.
module rom_programmer #(
  parameter int DATA_WIDTH     = 8,
  parameter int ADDRESS_WIDTH  = 9,
  parameter int WORD_COUNT     = 512,
  parameter int SETUP_CYCLES   = 4,
  parameter int PULSE_CYCLES   = 16,
  parameter int RECOVER_CYCLES = 4,
  parameter int MAX_RETRIES    = 3
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     start,
  input  logic [DATA_WIDTH-1:0]    word_in,
  input  logic                     word_valid,
  output logic                     word_ready,
  input  logic [DATA_WIDTH-1:0]    data_line_in,
  output logic [3:0]               operation,
  output logic [ADDRESS_WIDTH-1:0] address_line,
  output logic [DATA_WIDTH-1:0]    data_line_out,
  output logic                     data_oe,
  output logic                     busy,
  output logic                     done,
  output logic                     error,
  output logic [ADDRESS_WIDTH-1:0] error_address
);

`ifdef ROM_PROGRAMMER_VERIFY_EN
  localparam bit VERIFY = 1'b1;
`else
  localparam bit VERIFY = 1'b0;
`endif

  localparam logic [3:0] OP_READ  = 4'b1100;
  localparam logic [3:0] OP_SETUP = 4'b1000;
  localparam logic [3:0] OP_PULSE = 4'b0010;
  localparam int         CNT_W    = 16;
  localparam int         RETRY_W  = 8;
  localparam logic [ADDRESS_WIDTH-1:0] LAST_ADDRESS = ADDRESS_WIDTH'(WORD_COUNT - 1);

  typedef enum logic [2:0] {
    IDLE, WAIT_WORD, SETUP, PULSE, RECOVER, CHECK, DONE, ERROR
  } state_t;

  state_t               state, state_next;
  logic [CNT_W-1:0]     phase_cnt;
  logic [RETRY_W-1:0]   retries;
  logic [DATA_WIDTH-1:0] sample;
  logic                 verify_ok;
  logic                 run_clear, word_load, sample_en, addr_inc, retry_inc, fail_latch;

  always_comb begin
    // NOTE: every signal driven here gets a default first, so no path can infer a latch.
    state_next = state;
    operation  = OP_READ;
    word_ready = 1'b0;
    data_oe    = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    run_clear  = 1'b0;
    word_load  = 1'b0;
    sample_en  = 1'b0;
    addr_inc   = 1'b0;
    retry_inc  = 1'b0;
    fail_latch = 1'b0;
    verify_ok  = !VERIFY || (sample == data_line_out);

    case (state)
      IDLE, ERROR: begin
        if (start) begin
          run_clear  = 1'b1;
          state_next = WAIT_WORD;
        end
      end
      WAIT_WORD: begin
        busy       = 1'b1;
        word_ready = 1'b1;
        if (word_valid) begin
          word_load  = 1'b1;
          state_next = SETUP;
        end
      end
      SETUP: begin
        busy      = 1'b1;
        operation = OP_SETUP;
        data_oe   = 1'b1;
        if (phase_cnt == CNT_W'(SETUP_CYCLES - 1)) state_next = PULSE;
      end
      PULSE: begin
        busy      = 1'b1;
        operation = OP_PULSE;
        data_oe   = 1'b1;
        if (phase_cnt == CNT_W'(PULSE_CYCLES - 1)) state_next = RECOVER;
      end
      RECOVER: begin
        busy = 1'b1;
        // The chip output has settled by the final recover cycle, so sample there.
        if (phase_cnt == CNT_W'(RECOVER_CYCLES - 1)) begin
          sample_en  = 1'b1;
          state_next = CHECK;
        end
      end
      CHECK: begin
        busy = 1'b1;
        if (verify_ok) begin
          if (address_line == LAST_ADDRESS) begin
            state_next = DONE;
          end else begin
            addr_inc   = 1'b1;
            state_next = WAIT_WORD;
          end
        end else if (retries < RETRY_W'(MAX_RETRIES)) begin
          retry_inc  = 1'b1;
          state_next = SETUP;
        end else begin
          fail_latch = 1'b1;
          state_next = ERROR;
        end
      end
      DONE: begin
        busy       = 1'b1;
        done       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state         <= IDLE;
      phase_cnt     <= '0;
      address_line  <= '0;
      data_line_out <= '0;
      retries       <= '0;
      sample        <= '0;
      error         <= 1'b0;
      error_address <= '0;
    end else begin
      // NOTE: non-blocking updates so every register sees pre-edge values of its peers.
      state     <= state_next;
      phase_cnt <= (state_next == state) ? phase_cnt + CNT_W'(1) : '0;
      if (run_clear) begin
        address_line  <= '0;
        retries       <= '0;
        error         <= 1'b0;
        error_address <= '0;
      end
      if (word_load) data_line_out <= word_in;
      if (sample_en) sample <= data_line_in;
      if (addr_inc) begin
        address_line <= address_line + ADDRESS_WIDTH'(1);
        retries      <= '0;
      end
      if (retry_inc) retries <= retries + RETRY_W'(1);
      if (fail_latch) begin
        error         <= 1'b1;
        error_address <= address_line;
      end
    end
  end

endmodule

// File: tb/tb_rom_programmer.sv
// Self-checking bench for rom_programmer: a behavioural PROM model plus a per-run reference of
// expected burn phases, busy time, done pulses and error outcome.
module tb_rom_programmer;

`ifdef ROM_PROGRAMMER_VERIFY_EN
  localparam bit VERIFY = 1'b1;
`else
  localparam bit VERIFY = 1'b0;
`endif

  localparam int DW = 8, AW = 9, NW = 4, S = 4, P = 16, R = 4, MAXR = 3, SEGS = 64;
  localparam logic [3:0] OP_READ = 4'b1100, OP_SETUP = 4'b1000, OP_PULSE = 4'b0010;

  logic          clk = 1'b0, reset_n = 1'b0, start = 1'b0, word_valid = 1'b0;
  logic [DW-1:0] word_in = '0;
  logic [DW-1:0] data_line_in;
  logic          word_ready, data_oe, busy, done, error;
  logic [3:0]    operation;
  logic [AW-1:0] address_line, error_address;
  logic [DW-1:0] data_line_out;

  int compared = 0, mismatched = 0;

  rom_programmer #(
    .DATA_WIDTH(DW), .ADDRESS_WIDTH(AW), .WORD_COUNT(NW),
    .SETUP_CYCLES(S), .PULSE_CYCLES(P), .RECOVER_CYCLES(R), .MAX_RETRIES(MAXR)
  ) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .word_in(word_in), .word_valid(word_valid),
    .word_ready(word_ready), .data_line_in(data_line_in), .operation(operation),
    .address_line(address_line), .data_line_out(data_line_out), .data_oe(data_oe),
    .busy(busy), .done(done), .error(error), .error_address(error_address)
  );

  always #5 clk = ~clk;

  // PROM model: a cell reads back its word only after chip_need pulses, otherwise chip_bad.
  logic [DW-1:0] chip_word [NW];
  logic [DW-1:0] chip_bad  [NW];
  int            chip_need [NW];
  int            hold_cycles [NW];
  int            pulse_cnt [NW];
  logic          prev_pulse;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NW; i++) pulse_cnt[i] <= 0;
      prev_pulse <= 1'b0;
    end else begin
      prev_pulse <= (operation == OP_PULSE);
      if (operation == OP_PULSE && !prev_pulse)
        pulse_cnt[address_line[1:0]] <= pulse_cnt[address_line[1:0]] + 1;
    end
  end

  assign data_line_in = (pulse_cnt[address_line[1:0]] >= chip_need[address_line[1:0]])
                        ? chip_word[address_line[1:0]] : chip_bad[address_line[1:0]];

  // Monitor: run-length segments of non-read activity, busy cycles and done pulses.
  logic [3:0]    seg_op   [SEGS];
  logic [AW-1:0] seg_addr [SEGS];
  logic          seg_oe   [SEGS];
  logic [DW-1:0] seg_data [SEGS];
  int            seg_len  [SEGS];
  int            seg_n, busy_cycles, done_pulses;
  logic          prev_nonread, prev_oe;
  logic [3:0]    prev_op;
  logic [AW-1:0] prev_addr;
  logic [DW-1:0] prev_data;

  always @(negedge clk) begin
    if (!reset_n) begin
      seg_n        <= 0;
      busy_cycles  <= 0;
      done_pulses  <= 0;
      prev_nonread <= 1'b0;
    end else begin
      if (busy) busy_cycles <= busy_cycles + 1;
      if (done) done_pulses <= done_pulses + 1;
      prev_nonread <= (operation != OP_READ);
      prev_op      <= operation;
      prev_addr    <= address_line;
      prev_oe      <= data_oe;
      prev_data    <= data_line_out;
      if (operation != OP_READ) begin
        if (seg_n > 0 && prev_nonread && prev_op == operation && prev_addr == address_line &&
            prev_oe == data_oe && prev_data == data_line_out)
          seg_len[seg_n-1] <= seg_len[seg_n-1] + 1;
        else if (seg_n < SEGS) begin
          seg_op[seg_n]   <= operation;
          seg_addr[seg_n] <= address_line;
          seg_oe[seg_n]   <= data_oe;
          seg_data[seg_n] <= data_line_out;
          seg_len[seg_n]  <= 1;
          seg_n           <= seg_n + 1;
        end
      end
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed 'h%0h, expected 'h%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] seg_pack(input logic [3:0] op, input logic [AW-1:0] a,
                                           input logic oe, input logic [DW-1:0] d, input int len);
    logic [15:0] l;
    l = len[15:0];
    return {26'b0, op, a, oe, d, l};
  endfunction

  task automatic check_idle_outputs(input string tag);
    check({tag, " operation"}, operation, OP_READ);
    check({tag, " address_line"}, address_line, 0);
    check({tag, " data_line_out"}, data_line_out, 0);
    check({tag, " data_oe/word_ready/busy/done/error"},
          {data_oe, word_ready, busy, done, error}, 5'b0);
    check({tag, " error_address"}, error_address, 0);
  endtask

  task automatic do_reset();
    reset_n    = 1'b0;
    start      = 1'b0;
    word_valid = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic set_ideal_chip();
    for (int i = 0; i < NW; i++) begin
      chip_need[i]   = 1;
      chip_bad[i]    = ~chip_word[i];
      hold_cycles[i] = 0;
    end
  endtask

  // Drives one complete run and compares everything seen with the reference outcome.
  task automatic run_burn(input string tag);
    int attempts [NW];
    int fail_at, words_fed, exp_busy, n, t;
    fail_at  = -1;
    exp_busy = 0;
    for (int i = 0; i < NW; i++) begin
      if (fail_at >= 0)                attempts[i] = 0;
      else if (!VERIFY)                attempts[i] = 1;
      else if (chip_need[i] <= MAXR+1) attempts[i] = chip_need[i];
      else begin
        attempts[i] = MAXR + 1;
        fail_at     = i;
      end
    end
    words_fed = (fail_at < 0) ? NW : fail_at + 1;
    for (int i = 0; i < words_fed; i++) exp_busy += hold_cycles[i] + 1 + attempts[i] * (S + P + R + 1);
    if (fail_at < 0) exp_busy += 1;

    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    for (int i = 0; i < words_fed; i++) begin
      t = 0;
      while (!word_ready && t < 200) begin @(negedge clk); t++; end
      check($sformatf("%s word_ready w%0d", tag, i), word_ready, 1);
      for (int j = 0; j < hold_cycles[i]; j++) begin
        check($sformatf("%s hold w%0d c%0d op/ready/addr", tag, i, j),
              {operation, word_ready, address_line}, {OP_READ, 1'b1, AW'(i)});
        @(negedge clk);
      end
      word_in    = chip_word[i];
      word_valid = 1'b1;
      @(posedge clk);
      #1 word_valid = 1'b0;
    end
    t = 0;
    while (busy && t < 1000) begin @(negedge clk); t++; end
    check({tag, " busy released"}, busy, 0);

    check({tag, " busy cycles"}, busy_cycles, exp_busy);
    check({tag, " done pulses"}, done_pulses, (fail_at < 0) ? 1 : 0);
    check({tag, " error"}, error, (fail_at >= 0) ? 1 : 0);
    if (fail_at >= 0) check({tag, " error_address"}, error_address, fail_at);
    check({tag, " idle op/oe/ready"}, {operation, data_oe, word_ready}, {OP_READ, 1'b0, 1'b0});

    n = 0;
    for (int i = 0; i < words_fed; i++) begin
      for (int a = 0; a < attempts[i]; a++) begin
        if (n < seg_n)
          check($sformatf("%s seg%0d setup", tag, n),
                seg_pack(seg_op[n], seg_addr[n], seg_oe[n], seg_data[n], seg_len[n]),
                seg_pack(OP_SETUP, AW'(i), 1'b1, chip_word[i], S));
        if (n + 1 < seg_n)
          check($sformatf("%s seg%0d pulse", tag, n + 1),
                seg_pack(seg_op[n+1], seg_addr[n+1], seg_oe[n+1], seg_data[n+1], seg_len[n+1]),
                seg_pack(OP_PULSE, AW'(i), 1'b1, chip_word[i], P));
        n += 2;
      end
    end
    check({tag, " segment count"}, seg_n, n);
  endtask

  initial begin
    int pt;
    for (int i = 0; i < NW; i++) chip_word[i] = '0;
    set_ideal_chip();

    #1 check_idle_outputs("reset");
    do_reset();

    // Four fixed words, ideal read-back.
    chip_word[0] = 8'hA5; chip_word[1] = 8'h3C; chip_word[2] = 8'hFF; chip_word[3] = 8'h00;
    set_ideal_chip();
    run_burn("basic");

    // Supplier stalls ten cycles before word 1.
    do_reset();
    hold_cycles[1] = 10;
    run_burn("stall");

    // start pulsed in the middle of the address-1 pulse must be ignored.
    do_reset();
    set_ideal_chip();
    fork
      run_burn("start_in_pulse");
      begin
        pt = 0;
        while (!(operation == OP_PULSE && address_line == 1) && pt < 500) begin
          @(negedge clk); pt++;
        end
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
      end
    join

    // Read-back wrong twice at address 2.
    do_reset();
    set_ideal_chip();
    chip_need[2] = 3;
    run_burn("retry");

    // Cell at address 1 stuck at zero for word 0x81; a later start clears error.
    do_reset();
    chip_word[1] = 8'h81;
    set_ideal_chip();
    chip_need[1] = 1000;
    chip_bad[1]  = 8'h00;
    run_burn("stuck");
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    check("restart error/busy", {error, busy}, 2'b01);
    check("restart error_address", error_address, 0);

    // Randomized runs.
    for (int r = 0; r < 3; r++) begin
      do_reset();
      for (int i = 0; i < NW; i++) chip_word[i] = DW'($urandom);
      set_ideal_chip();
      for (int i = 0; i < NW; i++) begin
        hold_cycles[i] = $urandom_range(0, 3);
        chip_need[i]   = $urandom_range(1, 5);
      end
      run_burn($sformatf("rand%0d", r));
    end

    // Asynchronous reset on the fifth cycle of the address-1 pulse.
    do_reset();
    set_ideal_chip();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    word_in    = 8'h5A;
    word_valid = 1'b1;
    pt = 0;
    while (!(operation == OP_PULSE && address_line == 1) && pt < 500) begin
      @(negedge clk); pt++;
    end
    repeat (4) @(negedge clk);
    check("mid-pulse op before reset", {operation, data_oe, busy}, {OP_PULSE, 1'b1, 1'b1});
    #2 reset_n = 1'b0;
    #1 check_idle_outputs("mid-pulse reset");
    word_valid = 1'b0;
    do_reset();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
